// File: rtl/dly_pkg.sv
// Shared helpers and types for the bus delay line and its warm-up counter.
package dly_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int DLY_MAX = 256;
  localparam int COUNT_W = clog2(DLY_MAX + 1);

  typedef logic [COUNT_W-1:0] cnt_t;

endpackage

// File: rtl/dly_warmup_cnt.sv
// Saturating warm-up counter: counts enabled edges since reset/clear, stops at LIMIT,
// and flags when LIMIT has been reached.
module dly_warmup_cnt
  import dly_pkg::*;
#(
  parameter int CNT_W = COUNT_W,
  parameter int LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_primed
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             primed_reg;

  always_comb begin
    count_next = count_reg;
    if (i_clr) begin
      count_next = '0;
    end else if (i_en && (count_reg != CNT_W'(LIMIT))) begin
      count_next = count_reg + 1'b1;
    end
  end

  // The flag is derived from the next count so it changes on the same edge as the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg  <= '0;
      primed_reg <= 1'b0;
    end else begin
      count_reg  <= count_next;
      primed_reg <= (count_next == CNT_W'(LIMIT));
    end
  end

  assign o_count  = count_reg;
  assign o_primed = primed_reg;

endmodule

// File: rtl/delay_bus_line.sv
// WIDTH-bit delay line of DLY_CYCLE enabled stages with stall, flush and primed flag.
// Optional runtime tap select is enabled by defining DLY_BUS_TAP_EN.
module delay_bus_line
  import dly_pkg::*;
#(
  parameter int               WIDTH     = 3,
  parameter int               DLY_CYCLE = 8,
  parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_en,
  input  logic                              i_clr,
  input  logic [WIDTH-1:0]                  i_data,
`ifdef DLY_BUS_TAP_EN
  input  logic [clog2(DLY_CYCLE + 1)-1:0]   i_tap,
`endif
  output logic [WIDTH-1:0]                  o_data,
  output logic                              o_primed
);

  logic [WIDTH-1:0] stage_q [DLY_CYCLE];
  cnt_t             count;
  logic             cnt_primed;

  genvar gi;
  generate
    for (gi = 0; gi < DLY_CYCLE; gi++) begin : g_stage
      logic [WIDTH-1:0] d_next;
      logic [WIDTH-1:0] q_reg;

      if (gi == 0) begin : g_head
        assign d_next = i_data;
      end else begin : g_tail
        assign d_next = stage_q[gi-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_reg <= RST_VAL;
        end else if (i_clr) begin
          q_reg <= RST_VAL;
        end else if (i_en) begin
          q_reg <= d_next;
        end
      end

      assign stage_q[gi] = q_reg;
    end
  endgenerate

  dly_warmup_cnt #(
    .CNT_W (COUNT_W),
    .LIMIT (DLY_CYCLE)
  ) u_warmup (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (i_en),
    .i_clr    (i_clr),
    .o_count  (count),
    .o_primed (cnt_primed)
  );

`ifdef DLY_BUS_TAP_EN
  int tap_sel;

  // Tap 0 reads as 1 and taps beyond the line length read the last stage.
  always_comb begin
    tap_sel = int'(i_tap);
    if (tap_sel == 0) begin
      tap_sel = 1;
    end else if (tap_sel > DLY_CYCLE) begin
      tap_sel = DLY_CYCLE;
    end
    o_data = stage_q[DLY_CYCLE-1];
    for (int k = 0; k < DLY_CYCLE; k++) begin
      if (k == tap_sel - 1) o_data = stage_q[k];
    end
  end

  assign o_primed = cnt_primed | (count >= cnt_t'(tap_sel));
`else
  assign o_data   = stage_q[DLY_CYCLE-1];
  // Both terms agree when the counter limit matches the line length.
  assign o_primed = cnt_primed & (count == cnt_t'(DLY_CYCLE));
`endif

endmodule

// File: doc/delay_bus_line.md
Name: delay_bus_line

Overview:
- Parametrised multi-bit delay line for aligning sync/control bundles (vsync, hsync, de, flags) with pixel data in the lane-detection video pipeline.
- Delays a WIDTH-bit bus by DLY_CYCLE enabled clock cycles; the DLY_CYCLE parameter is fully honoured.
- Adds pipeline-stall enable, synchronous flush and a programmable reset/flush value.
- Reports a primed flag once the line holds only real input samples.

Parameters:
- WIDTH, 3, number of bits delayed in parallel; range 1..64.
- DLY_CYCLE, 8, delay in enabled cycles; range 1..256.
- RST_VAL, 0 (WIDTH bits), value loaded into every stage on reset and on flush; per-bit, e.g. 1 for active-low syncs.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- i_en  input  1  stage advance enable; low = hold all stages (stall).
- i_clr  input  1  synchronous flush.
- i_data  input  WIDTH  bus to delay.
- o_data  output  WIDTH  delayed bus.
- o_primed  output  1  high when every stage feeding o_data holds sampled input.
- i_tap  input  clog2(DLY_CYCLE+1)  runtime delay select; present only with DLY_BUS_TAP_EN.

Behaviour:
- Storage: DLY_CYCLE registers, stage[0]..stage[DLY_CYCLE-1], all on clk with asynchronous rst_n.
- Reset (rst_n=0): all stages = RST_VAL, o_data = RST_VAL, warm-up count = 0, o_primed = 0.
- Priority per edge: rst_n, then i_clr, then i_en.
- i_clr=1: all stages = RST_VAL and count = 0 at the next edge, regardless of i_en. Input sampled on a clear cycle is discarded.
- i_en=1, i_clr=0: stage[0] <= i_data; stage[k] <= stage[k-1]; count <= min(count+1, DLY_CYCLE).
- i_en=0, i_clr=0: all stages and count hold.
- o_data = stage[DLY_CYCLE-1], a registered output with no combinational path from i_data.
- Latency: the sample taken at the j-th enabled edge appears on o_data after the (j+DLY_CYCLE-1)-th enabled edge, i.e. DLY_CYCLE enabled cycles. With i_en tied high, o_data(t+DLY_CYCLE) = i_data(t).
- DLY_CYCLE=1: single register; o_primed rises after the first enabled edge.
- o_primed = (count == DLY_CYCLE), registered. The count saturates and never wraps.
- o_primed stays high through stalls and falls only on reset or i_clr.
- Reset release mid-stream: the pipeline restarts from RST_VAL; no stale data emerges.

Optional Feature:
- Macro: DLY_BUS_TAP_EN.
- Defined:
  - Port i_tap exists.
  - o_data = stage[i_tap-1], a combinational mux from the registers.
  - i_tap=0 is treated as 1; i_tap > DLY_CYCLE is clamped to DLY_CYCLE.
  - o_primed = (count >= effective tap).
  - A tap change takes effect on the same cycle; no flush is implied.
  - Decreasing the tap drops in-flight samples. Increasing the tap re-exposes older samples, and o_primed may fall until count catches up.
- Undefined: no i_tap port; fixed delay of DLY_CYCLE as above.

Decomposition:
- Package dly_pkg:
  - function clog2.
  - localparam DLY_MAX = 256.
  - typedef for the count width, clog2(DLY_MAX+1).
- Sub-module dly_warmup_cnt: saturating enabled counter with clear, count width and saturation limit as parameters. It produces the count and o_primed; the top holds the stage array and the output mux.

Test Plan:
- Reset value: WIDTH=3, RST_VAL=3'b011, DLY_CYCLE=8; hold rst_n low, drive i_data=3'b100 -> o_data=3'b011 and o_primed=0 throughout reset and for 7 enabled cycles after release.
- Latency: i_en=1; ramp i_data 0,1,2,...,7 repeating from cycle 0 -> o_data equals the cycle-0 value 8 edges later, then tracks the ramp exactly 8 cycles behind; o_primed rises after the 8th enabled edge.
- Stall: with a ramp running, drop i_en for cycles 3-5 -> o_data frozen for 3 cycles, the sequence resumes with no skipped or duplicated value, and o_primed is unchanged.
- Flush: at cycle 20 assert i_clr with i_en=1 -> next o_data=RST_VAL and o_primed=0; the first post-flush sample appears 8 enabled edges after clear deassertion.
- Corner case: DLY_CYCLE=1 with random i_data -> o_data(t+1)=i_data(t), and o_primed=1 after the first enabled edge.
- Runtime tap (DLY_BUS_TAP_EN): DLY_CYCLE=8, i_tap=3 -> delay 3. Switch to i_tap=6 -> o_data shows the sample from 6 cycles ago on the same cycle. i_tap=0 behaves as 1; i_tap=15 behaves as 8.
